// File: rtl/phase_shift_divider.sv
// Programmable half-period clock divider with phase advance/retard by pulse deletion/insertion.
// Define DPKD_SHIFT_ACCUM_EN to replace the single pending shift with a saturating accumulator.
module phase_shift_divider #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHIFT_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             positiveShift_i,
  input  logic             negativeShift_i,
  output logic             output_o,
  output logic             tc_o,
  output logic             shift_drop_o
);

  localparam int unsigned CW = WIDTH + 1;

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t                    state;
  logic [WIDTH-1:0]          count;
  logic signed [SHIFT_W-1:0] pending;

  logic signed [SHIFT_W-1:0] req_c;
  logic signed [SHIFT_W-1:0] merged_c;
  logic signed [SHIFT_W-1:0] pend_after_c;
  logic                      merge_drop_c;
  logic                      apply_drop_c;
  logic                      adv_c;
  logic                      ret_c;
  logic                      reload_edge_c;
  logic [CW-1:0]             d_c;
  logic [CW-1:0]             len_c;
  logic [WIDTH-1:0]          reload_c;

`ifdef DPKD_SHIFT_ACCUM_EN
  localparam logic signed [SHIFT_W-1:0] PEND_MAX = {1'b0, {(SHIFT_W-1){1'b1}}};
  localparam logic signed [SHIFT_W-1:0] PEND_MIN = {1'b1, {(SHIFT_W-1){1'b0}}};
`endif

  // Net request of this edge: +1 advance, -1 retard, simultaneous requests cancel.
  always_comb begin
    req_c = '0;
    if (positiveShift_i && !negativeShift_i) begin
      req_c = SHIFT_W'(1);
    end else if (negativeShift_i && !positiveShift_i) begin
      req_c = '1;
    end
  end

  // Merge the request into the pending shift, flagging requests that cannot be held.
  always_comb begin
    merged_c     = pending;
    merge_drop_c = 1'b0;
`ifdef DPKD_SHIFT_ACCUM_EN
    if ((req_c == SHIFT_W'(1)) && (pending == PEND_MAX)) begin
      merge_drop_c = 1'b1;
    end else if ((req_c == '1) && (pending == PEND_MIN)) begin
      merge_drop_c = 1'b1;
    end else begin
      merged_c = pending + req_c;
    end
`else
    if (req_c != '0) begin
      if (pending == '0) begin
        merged_c = req_c;
      end else if (pending == req_c) begin
        merge_drop_c = 1'b1;
      end else begin
        merged_c = '0;
      end
    end
`endif
  end

  // Reload length: one unit of pending shift is applied per reload, advance cannot go below 1.
  always_comb begin
    reload_edge_c = (state == ST_LOAD) || (count == '0);
    d_c           = (div_i == '0) ? CW'(1) : {1'b0, div_i};
    adv_c         = !merged_c[SHIFT_W-1] && (merged_c != '0);
    ret_c         = merged_c[SHIFT_W-1];
    len_c         = d_c;
    apply_drop_c  = 1'b0;
    if (adv_c) begin
      if (d_c == CW'(1)) begin
        apply_drop_c = 1'b1;
      end else begin
        len_c = d_c - CW'(1);
      end
    end else if (ret_c) begin
      len_c = d_c + CW'(1);
    end
    reload_c = WIDTH'(len_c - CW'(1));
`ifdef DPKD_SHIFT_ACCUM_EN
    if (adv_c) begin
      pend_after_c = merged_c - SHIFT_W'(1);
    end else if (ret_c) begin
      pend_after_c = merged_c + SHIFT_W'(1);
    end else begin
      pend_after_c = merged_c;
    end
`else
    pend_after_c = '0;
`endif
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state        <= ST_LOAD;
      count        <= '0;
      pending      <= '0;
      output_o     <= 1'b0;
      tc_o         <= 1'b0;
      shift_drop_o <= 1'b0;
    end else begin
      tc_o         <= 1'b0;
      shift_drop_o <= 1'b0;
      if (en_i) begin
        if (reload_edge_c) begin
          state        <= ST_RUN;
          count        <= reload_c;
          pending      <= pend_after_c;
          shift_drop_o <= merge_drop_c | apply_drop_c;
          if (state == ST_RUN) begin
            output_o <= ~output_o;
            tc_o     <= 1'b1;
          end
        end else begin
          count        <= count - WIDTH'(1);
          pending      <= merged_c;
          shift_drop_o <= merge_drop_c;
        end
      end
    end
  end

endmodule

// File: doc/phase_shift_divider.md
Name: phase_shift_divider

Overview:
- Programmable clock divider for the DPKD loop. Generalises the fixed divider to any WIDTH, a run-time ratio, and phase advance/retard by pulse deletion/insertion.
- The divided output toggles every L clocks. L is the reloaded half-period length.
- The loop filter drives the shift requests to pull output phase by one input clock per request.
- A status strobe marks every output edge, for the phase detector.

Parameters:
- WIDTH, 8, width of divide ratio and half-period counter.
- SHIFT_W, 4, width of signed shift accumulator (used only with SHIFT_ACCUM_EN).

Ports:
- clk_i  in  1  input reference clock
- reset_i  in  1  asynchronous active-low reset
- en_i  in  1  count enable; low freezes counter, output and pending shifts
- div_i  in  WIDTH  half-period ratio D; 0 is treated as 1
- positiveShift_i  in  1  one-cycle request: advance phase (shorten next half-period by 1)
- negativeShift_i  in  1  one-cycle request: retard phase (lengthen next half-period by 1)
- output_o  out  1  divided clock, period 2*L clocks
- tc_o  out  1  one-cycle strobe, asserted on the cycle output_o toggles
- shift_drop_o  out  1  one-cycle strobe when a shift request is discarded

Behaviour:
- Interface: one clock (clk_i, rising edge); reset_i asynchronous, active-low. No other clocks or resets.
- Reset values: output_o=0, tc_o=0, shift_drop_o=0, counter=0, pending shift=0, FSM=LOAD.
- FSM LOAD: first enabled edge after reset. Counter <= L-1, FSM -> RUN. No toggle, no tc_o.
- FSM RUN, counter != 0: counter decrements.
- FSM RUN, counter == 0 (reload edge): output_o toggles, tc_o=1, counter <= L-1.
- Half-period equals L clocks exactly.
- L = D + adj. D = max(div_i, 1), sampled only at LOAD/reload edges. Mid-period div_i changes have no effect until the next reload, so output is glitch-free.
- adj = -1 if the applied shift is advance, +1 if retard, 0 otherwise.
- Arithmetic is WIDTH+1 bits. L-1 max = 2^WIDTH-1, so the counter is WIDTH bits.
- Advance with D == 1 would give L=0: shift discarded, L=1, shift_drop_o=1 on that reload edge.
- Request capture: requests are sampled on every enabled edge. A request arriving on a reload edge is merged and applied to that same reload.
- Both shift inputs high on one edge: the two cancel, no change, no drop.
- Pending (macro off): pending ∈ {-1,0,+1}.
  - Same-sign request while pending: ignored, shift_drop_o=1.
  - Opposite-sign request: pending -> 0.
  - Pending is cleared by the reload that applies it.
- en_i=0: all state holds; requests are ignored (not captured, no drop strobe); tc_o=0.
- Reset asserted mid-period: outputs clear immediately (asynchronously); restart through LOAD.
- tc_o and shift_drop_o are registered and high for exactly one cycle.

Optional Feature:
- Macro: DPKD_SHIFT_ACCUM_EN.
- Defined:
  - Pending becomes a signed SHIFT_W saturating accumulator. +1 per advance, -1 per retard; simultaneous requests net 0.
  - A request that would exceed +(2^(SHIFT_W-1)-1) or -(2^(SHIFT_W-1)) is dropped with shift_drop_o.
  - Each reload applies one unit (adj=±1) toward zero, so multiple requests spread over consecutive half-periods.
- Undefined: single-entry pending as above.

Test Plan:
- Reset release, div_i=4, no shifts -> first toggle 5 edges after release (LOAD + 4); then output_o toggles every 4 clocks; tc_o pulses coincide with toggles.
- div_i=4 running, pulse positiveShift_i mid-period -> next half-period 3 clocks, following ones 4; one negativeShift_i pulse -> one half-period of 5.
- div_i changes 4->7 mid-period -> current half-period completes at 4; next is 7. div_i=0 -> half-period 1 (output toggles every clock).
- Both shift inputs high on the same edge -> no period change, shift_drop_o stays 0. div_i=1 with advance -> period unchanged at 1, shift_drop_o=1 at reload.
- Macro off: two advance pulses in one period -> second gives shift_drop_o=1; only one half-period shortened. Macro on, SHIFT_W=4: three advances -> three consecutive half-periods of D-1; eight advances -> eighth dropped.
- Assert reset_i low mid-period with output_o=1 -> output_o=0 immediately; en_i=0 for 10 cycles -> output and counter frozen, then resume with the remaining count.
